// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the burst-locked round-robin arbiters.
package axi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_REQ_NUM = 4;
    localparam int ARB_DATA_W  = 32;

    // Index of the set bit in a one-hot vector of up to 16 requesters; 0 when empty.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_ptr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping, found by scanning
// a doubled request vector so the wrap needs no modulo on the pointer.
module rr_ptr_pick #(
    parameter  int REQ_NUM = 4,
    localparam int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [2*REQ_NUM-1:0] req_dbl;

    always_comb begin
        req_dbl = {req, req};
        found   = 1'b0;
        idx     = '0;
        // Downward scan: the last hit written is the lowest position inside the window.
        for (int i = 2*REQ_NUM-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(ptr)) && (i < int'(ptr) + REQ_NUM)) begin
                found = 1'b1;
                idx   = IDX_W'(i % REQ_NUM);
            end
        end
    end

endmodule

// File: rtl/axi_burst_rr_arbiter.sv
// Round-robin arbiter for a shared valid/ready stream; the grant is locked for a whole
// burst and a last beat (or watchdog expiry) re-arbitrates in the same cycle.
module axi_burst_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int REQ_NUM   = ARB_REQ_NUM,
    parameter  int DATA_W    = ARB_DATA_W,
    parameter  int MAX_BEATS = 16,
    localparam int IDX_W     = $clog2(REQ_NUM)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [REQ_NUM-1:0]        s_valid,
    input  logic [REQ_NUM-1:0]        s_last,
    input  logic [REQ_NUM*DATA_W-1:0] s_data,
    output logic [REQ_NUM-1:0]        s_ready,
    output logic                      m_valid,
    output logic                      m_last,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_ready,
    output logic [REQ_NUM-1:0]        grant,
    output logic                      busy,
    output logic                      wdog_err
);

    localparam int BEAT_W = $clog2(MAX_BEATS);

    arb_state_e         state_q, state_d;
    logic [REQ_NUM-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               wdog_q, wdog_d;

    logic [IDX_W-1:0]   g_idx, ptr_rel, pick_ptr, pick_idx;
    logic               granted, hs, last_hs, wdog_hit, rel, pick_found;

    assign g_idx   = IDX_W'(onehot_to_idx(16'(grant_q)));
    assign granted = |grant_q;

    // Everything downstream is gated by the registered grant, so reset silences it at once.
    assign m_valid = granted & s_valid[g_idx];
    assign m_last  = granted & s_last[g_idx];
    assign m_data  = granted ? s_data[g_idx*DATA_W +: DATA_W] : '0;
    assign s_ready = grant_q & {REQ_NUM{m_ready}};

    assign hs       = m_valid & m_ready;
    assign last_hs  = hs & m_last;
    assign wdog_hit = hs & ~m_last & (beat_cnt_q == BEAT_W'(MAX_BEATS-1));
    assign rel      = last_hs | wdog_hit;

    assign ptr_rel  = (g_idx == IDX_W'(REQ_NUM-1)) ? '0 : g_idx + 1'b1;
    assign pick_ptr = (state_q == BUSY) ? ptr_rel : ptr_q;

    rr_ptr_pick #(
        .REQ_NUM (REQ_NUM)
    ) u_pick (
        .req   (s_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        wdog_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BUSY;
                    grant_d    = REQ_NUM'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d      = ptr_rel;
                    wdog_d     = wdog_hit;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = REQ_NUM'(1) << pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == BUSY);
    assign wdog_err = wdog_q;

endmodule

// File: tb/tb_axi_burst_rr_arbiter.sv
// Directed bench for axi_burst_rr_arbiter: behavioural burst sources per requester and
// hand-computed grant orders checked beat by beat.
module tb_axi_burst_rr_arbiter;

    localparam int REQ_NUM   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic [REQ_NUM-1:0]        s_valid, s_last, s_ready, grant;
    logic [REQ_NUM*DATA_W-1:0] s_data;
    logic                      m_valid, m_last, m_ready, busy, wdog_err;
    logic [DATA_W-1:0]         m_data;

    int checks = 0;
    int errors = 0;

    int rem[REQ_NUM];
    int blen[REQ_NUM];
    int nburst[REQ_NUM];
    int seq[REQ_NUM];
    int exp_q[$];

    logic [REQ_NUM-1:0] smp_grant, smp_sready;
    logic               smp_mvalid, smp_busy, smp_wdog;

    always #5 clk = ~clk;

    axi_burst_rr_arbiter #(
        .REQ_NUM   (REQ_NUM),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .grant    (grant),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < REQ_NUM; i++) begin
            s_valid[i] = (rem[i] > 0);
            s_last[i]  = (rem[i] == 1);
            s_data[i*DATA_W +: DATA_W] = {8'(i + 1), 24'(seq[i])};
        end
    endtask

    task automatic set_src(input int i, input int len, input int bursts);
        rem[i]    = len;
        blen[i]   = len;
        nburst[i] = bursts - 1;
    endtask

    // One clock: drive at negedge, sample 2 time units later, advance sources, wait next negedge.
    task automatic step();
        int e;
        logic [REQ_NUM-1:0] oh;
        drive();
        #2;
        smp_grant  = grant;
        smp_sready = s_ready;
        smp_mvalid = m_valid;
        smp_busy   = busy;
        smp_wdog   = wdog_err;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                oh = 4'(1 << e);
                chk("hs_grant", 32'(grant), 32'(oh));
                chk("hs_data", m_data, {8'(e + 1), 24'(seq[e])});
                chk("hs_last", 32'(m_last), 32'(rem[e] == 1));
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                rem[i]--;
                seq[i]++;
                if (rem[i] == 0 && nburst[i] > 0) begin
                    nburst[i]--;
                    rem[i] = blen[i];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < REQ_NUM; i++) begin
            rem[i]    = 0;
            blen[i]   = 0;
            nburst[i] = 0;
        end
        drive();
        exp_q.delete();
        @(negedge clk);
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);
        chk("rst_mdata", m_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic rdy_pat[5];
        int   wd;

        for (int i = 0; i < REQ_NUM; i++) seq[i] = 0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;

        // 1-beat bursts on requesters 0 and 2: one bubble, then alternate with no gap.
        do_reset();
        set_src(0, 1, 2);
        set_src(2, 1, 2);
        exp_q = '{0, 2, 0, 2};
        step();
        chk("t1_bubble", 32'(smp_grant), 32'h0);
        step();
        chk("t1_first", 32'(smp_grant), 32'h1);
        repeat (3) step();
        chk("t1_done", 32'(exp_q.size()), 32'd0);

        // All four requesters, 3-beat bursts, requester 0 comes back for a second burst.
        do_reset();
        for (int i = 0; i < REQ_NUM; i++) set_src(i, 3, 1);
        set_src(0, 3, 2);
        exp_q = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
        repeat (16) step();
        chk("t2_done", 32'(exp_q.size()), 32'd0);
        repeat (2) step();
        chk("t2_hold_novalid", 32'(smp_mvalid), 32'd0);
        chk("t2_hold_grant", 32'(smp_grant), 32'h1);

        // Requester 2 bursting under a stalling master; requester 3 waits.
        do_reset();
        set_src(2, 3, 1);
        set_src(3, 1, 1);
        exp_q   = '{2, 2, 2};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        step();
        for (int k = 0; k < 5; k++) begin
            m_ready = rdy_pat[k];
            step();
            chk("t3_grant", 32'(smp_grant), 32'h4);
            chk("t3_other_ready", 32'(smp_sready & 4'b1011), 32'd0);
            chk("t3_ready2", 32'(smp_sready[2]), 32'(rdy_pat[k]));
            chk("t3_valid", 32'(smp_mvalid), 32'd1);
        end
        m_ready = 1'b1;
        chk("t3_done", 32'(exp_q.size()), 32'd0);

        // Requester 1 never sends last: watchdog after 16 beats hands over to requester 3.
        do_reset();
        set_src(1, 1000, 1);
        set_src(3, 1, 1);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(1);
        wd = 0;
        for (int k = 0; k < 19; k++) begin
            step();
            if (smp_wdog) wd++;
            if (k == 17) begin
                chk("t4_wdog_pulse", 32'(smp_wdog), 32'd1);
                chk("t4_grant3", 32'(smp_grant), 32'h8);
            end
        end
        chk("t4_wdog_count", 32'(wd), 32'd1);
        chk("t4_done", 32'(exp_q.size()), 32'd0);

        // Lone requester 3 with back-to-back 2-beat bursts never drops back to IDLE.
        do_reset();
        set_src(3, 2, 3);
        exp_q = '{3, 3, 3, 3, 3, 3};
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t5_busy", 32'(smp_busy), 32'd1);
            chk("t5_grant", 32'(smp_grant), 32'h8);
        end
        chk("t5_done", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a requester 1 burst, then a fresh round from 0.
        do_reset();
        set_src(1, 5, 1);
        exp_q = '{1, 1};
        repeat (3) step();
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_mvalid", 32'(m_valid), 32'd0);
        chk("t6_sready", 32'(s_ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < REQ_NUM; i++) set_src(i, 1, 1);
        exp_q = '{0};
        step();
        chk("t6_idle", 32'(smp_grant), 32'h0);
        step();
        chk("t6_grant0", 32'(smp_grant), 32'h1);
        chk("t6_done", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_rr_arbiter.md
Name: axi_burst_rr_arbiter

Overview:
- Shares one AXI-style streaming channel (valid/ready/last/data) among REQ_NUM requesters.
- Uses round-robin arbitration.
- Unlike a per-cycle arbiter, the grant is locked for a whole burst: it is held from the first beat until the beat carrying last completes its handshake.
- Sits in front of a shared slave port, such as the W or R channel of the AXI interconnect.

Parameters:
- REQ_NUM, 4: number of requesters, 2..16.
- DATA_W, 32: payload width per beat.
- MAX_BEATS, 16: watchdog limit on beats per burst, >= 2.
- IDX_W, $clog2(REQ_NUM): localparam, index width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  REQ_NUM  per-requester beat valid.
- s_last  in  REQ_NUM  per-requester last-beat flag.
- s_data  in  REQ_NUM*DATA_W  packed payloads; requester i occupies [i*DATA_W +: DATA_W].
- s_ready  out  REQ_NUM  per-requester ready.
- m_valid  out  1  shared channel valid.
- m_last  out  1  shared channel last.
- m_data  out  DATA_W  shared channel payload.
- m_ready  in  1  shared channel ready.
- grant  out  REQ_NUM  one-hot registered grant, or zero.
- busy  out  1  high while a burst owns the channel.
- wdog_err  out  1  one-cycle pulse on a watchdog release.

Behaviour:
- Reset state: state=IDLE, grant=0, ptr=0, beat_cnt=0, busy=0, wdog_err=0. Because grant is 0, m_valid, m_last, s_ready and m_data are all 0.
- States are IDLE and BUSY. busy = (state==BUSY).
- Pick function:
  - Search s_valid starting at index ptr and upward, wrapping modulo REQ_NUM.
  - The first set bit is the winner.
  - No bits set means no winner.
- IDLE:
  - If any s_valid is set: grant <= onehot(winner), state <= BUSY, beat_cnt <= 0.
  - This costs one bubble cycle; no beat passes while in IDLE.
- BUSY, with g the granted index (combinational mux from grant):
  - m_valid = s_valid[g], m_data = s_data[g], m_last = s_last[g].
  - s_ready[g] = m_ready; all other s_ready bits are 0.
  - Non-granted s_valid and s_last are ignored.
- Beat handshake is m_valid & m_ready. On each handshake without last, beat_cnt <= beat_cnt+1.
- Release on a last handshake: ptr <= (g+1) mod REQ_NUM.
  - Re-arbitrate in the same cycle using the new ptr over the current s_valid. Requester g is included but at lowest priority.
  - If there is a winner: grant <= onehot(winner), stay in BUSY, beat_cnt <= 0. This gives back-to-back bursts with no bubble.
  - Otherwise: grant <= 0, state <= IDLE.
- Watchdog:
  - Fires on a handshake without last when beat_cnt == MAX_BEATS-1.
  - Force a release exactly like a last handshake.
  - wdog_err = 1 for one cycle, registered on the same edge as the release.
  - The forced beat itself is delivered with m_last=0.
- If the granted requester drops s_valid mid-burst, the grant is held, m_valid=0, and there is no timeout on idle cycles.
- m_ready=0 stalls: all state holds and no pointer movement occurs.
- A single-beat burst (valid and last on the first beat) is a legal burst.
- REQ_NUM not a power of two: the pointer wrap uses an explicit compare against REQ_NUM-1, not bit truncation.
- Asynchronous reset mid-burst: immediately returns to the reset state. The in-flight burst is abandoned, and no s_ready or m_valid glitch high occurs after rstn falls.

Decomposition:
- Shared package axi_arb_pkg holds:
  - the state enum {IDLE, BUSY};
  - default REQ_NUM/DATA_W constants;
  - a function onehot_to_idx.
- One natural combinational sub-module, rr_ptr_pick. It takes req[REQ_NUM] and ptr[IDX_W] and returns found and idx[IDX_W]. It is implemented as a double-width priority scan, and is reusable by the weighted round-robin arbiter.

Test Plan:
- Reset, then s_valid=4'b0101 with 1-beat bursts and m_ready=1 → grant sequence 0001, 0100, 0001, 0100. The first grant appears 1 cycle after valid, and there is no bubble between bursts.
- All four requesters valid with 3-beat bursts → grants 0001, 0010, 0100, 1000, 0001. Each grant is held exactly 3 handshake cycles, and m_data equals the granted requester's payload every beat.
- Requester 2 bursting, m_ready toggled 1,0,0,1,1 → grant stays 0100. Beats are delivered only on ready-high cycles, and non-granted s_ready stays 0 throughout.
- MAX_BEATS=16, requester 1 never asserts last → release after the 16th handshake with a wdog_err pulse of 1 cycle. ptr moves to 2, and requester 3 (pending) is granted next.
- Only requester 3 valid with back-to-back 2-beat bursts → re-granted 1000 immediately after each last with no IDLE cycle.
- rstn low mid-burst of requester 1 → grant=0, m_valid=0, s_ready=0 immediately. After release, s_valid=1111 grants 0001 (ptr reset to 0).
